sram_responder: RTL and testbench

- Responder end of the single-port SRAM access interface: accepts read/write requests from an initiator over a valid/ready handshake and returns read data over a valid/ready response channel.
- Owns a DEPTH x DATA_W storage array, sized to match the existing 64 x 8 SRAM.
- Zero-fills the whole array after every reset before it accepts any traffic.

---
 rtl/sram_responder.sv | 176 +++++++++++++++++
 tb/tb_sram_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
`timescale 1ns/1ps
// sram_responder: responder side of the single-port SRAM access interface.
// Owns a DEPTH x DATA_W array, zero-fills it after every reset, then serves
// writes (no response) and reads (one registered response) over valid/ready.
// Optional macro SRAM_PARITY_EN adds a stored even-parity bit per word,
// a perr_inject input and a rsp_perr output.
module sram_responder #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done
`ifdef SRAM_PARITY_EN
    ,
    input  logic              perr_inject,
    output logic              rsp_perr
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef SRAM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              init_done_q, init_done_d;
`ifdef SRAM_PARITY_EN
    logic              rsp_perr_q, rsp_perr_d;
`endif

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [WORD_W-1:0] mem_wword_c;
    logic [WORD_W-1:0] wr_word_c;
    logic [WORD_W-1:0] rd_word_c;
    logic              handshake_c;

    assign handshake_c = req_valid & req_ready_q;
    assign rd_word_c   = mem_q[raddr_q];

    // Word as stored: parity bit (inverted on injection) above the data.
`ifdef SRAM_PARITY_EN
    assign wr_word_c = {(^req_wdata) ^ perr_inject, req_wdata};
`else
    assign wr_word_c = req_wdata;
`endif

    // Next-state, array write port and registered output values.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        raddr_d     = raddr_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        init_done_d = init_done_q;
`ifdef SRAM_PARITY_EN
        rsp_perr_d  = rsp_perr_q;
`endif
        mem_we_c    = 1'b0;
        mem_waddr_c = clr_addr_q;
        mem_wword_c = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_addr_q;
                mem_wword_c = '0;
                clr_addr_d  = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    req_ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (handshake_c) begin
                    if (req_write) begin
                        mem_we_c    = 1'b1;
                        mem_waddr_c = req_addr;
                        mem_wword_c = wr_word_c;
                    end else begin
                        raddr_d     = req_addr;
                        state_d     = ST_READ;
                        req_ready_d = 1'b0;
                    end
                end
            end
            ST_READ: begin
                rsp_rdata_d = rd_word_c[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
                rsp_perr_d  = ^rd_word_c;
`endif
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and output registers; reset restarts the clear sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            raddr_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            init_done_q <= 1'b0;
`ifdef SRAM_PARITY_EN
            rsp_perr_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            raddr_q     <= raddr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_done_q <= init_done_d;
`ifdef SRAM_PARITY_EN
            rsp_perr_q  <= rsp_perr_d;
`endif
        end
    end

    // Storage array; contents are cleared by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wword_c;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;
`ifdef SRAM_PARITY_EN
    assign rsp_perr  = rsp_perr_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for sram_responder: directed cases plus random traffic
// checked against an array model of the memory.
module tb_sram_responder;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       init_done;
`ifdef SRAM_PARITY_EN
    logic       perr_inject;
    logic       rsp_perr;
`endif

    sram_responder #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
`ifdef SRAM_PARITY_EN
        ,
        .perr_inject (perr_inject),
        .rsp_perr    (rsp_perr)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_mem  [64];
    logic       model_perr [64];
    int         checks;
    int         errors;
    bit         rr_rand;
    bit         rr_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // rsp_ready driver: random or forced, updated just after each rising edge.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
        end
    end

    // Monitor: every accepted response is popped and compared.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got response 0x%0h with no read pending", rsp_rdata);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
`ifdef SRAM_PARITY_EN
                chk("rsp_perr", 32'(rsp_perr), 32'(e.perr));
`endif
            end
        end
    end

    // One request; returns #1 after its handshake edge with req_valid still high.
    task automatic issue(input bit wr, input logic [5:0] a, input logic [7:0] d, input bit pi);
        int n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
`ifdef SRAM_PARITY_EN
        perr_inject = pi;
`endif
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        if (wr) begin
            model_mem[a]  = d;
            model_perr[a] = pi;
        end else begin
            sb_q.push_back('{data: model_mem[a], perr: model_perr[a]});
        end
    endtask

    // Read with latency check: valid low after the handshake edge, high after the next.
    task automatic read_lat(input logic [5:0] a);
        issue(1'b0, a, 8'h00, 1'b0);
        req_valid = 1'b0;
        chk("lat_valid_after_hs", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_second_edge", 32'(rsp_valid), 32'd1);
    endtask

    // Release reset with a request held and count edges until req_ready rises.
    task automatic sweep_check(input logic [5:0] held_addr);
        int n = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = held_addr;
        req_wdata = 8'hEE;
        @(negedge clk);
        rst_n = 1'b1;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 63) chk("init_done_mid_sweep", 32'(init_done), 32'd0);
        end
        req_valid = 1'b0;
        chk("sweep_edges", 32'(n), 32'd64);
        chk("init_done_after_sweep", 32'(init_done), 32'd1);
        for (int i = 0; i < 64; i++) begin
            model_mem[i]  = 8'h00;
            model_perr[i] = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         wr;
        bit         pi;
        logic [5:0] a;
        logic [7:0] d;
        checks    = 0;
        errors    = 0;
        rr_rand   = 1'b0;
        rr_force  = 1'b1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef SRAM_PARITY_EN
        perr_inject = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_init_done", 32'(init_done), 32'd0);

        // Held write to 63 during the sweep must be ignored.
        sweep_check(6'd63);
        read_lat(6'd63);
        drain();

        // Back-to-back writes then reads in order.
        issue(1'b1, 6'd0, 8'h10, 1'b0);
        issue(1'b1, 6'd2, 8'h11, 1'b0);
        issue(1'b1, 6'd7, 8'hAF, 1'b0);
        req_valid = 1'b0;
        read_lat(6'd0);
        read_lat(6'd2);
        read_lat(6'd7);
        drain();

        // Read immediately after a write to the same address.
        issue(1'b1, 6'd3, 8'h5A, 1'b0);
        read_lat(6'd3);
        drain();

        // Stalled response on addr 7.
        rr_force = 1'b0;
        issue(1'b0, 6'd7, 8'h00, 1'b0);
        req_valid = 1'b0;
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_rdata", 32'(rsp_rdata), 32'hAF);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rr_force = 1'b1;
        @(posedge clk);
        #3;
        @(posedge clk);
        #1;
        chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        drain();

`ifdef SRAM_PARITY_EN
        // Injected parity error on addr 4 only.
        issue(1'b1, 6'd4, 8'h01, 1'b1);
        issue(1'b1, 6'd5, 8'h01, 1'b0);
        req_valid = 1'b0;
        read_lat(6'd4);
        read_lat(6'd5);
        drain();
`endif

        // Random traffic with random response back-pressure.
        rr_rand = 1'b1;
        repeat (300) begin
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
`ifdef SRAM_PARITY_EN
            pi = 1'($urandom_range(0, 1));
`else
            pi = 1'b0;
`endif
            issue(wr, a, d, pi);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        drain();

        // Reset while a read is in READ: response dropped, sweep reruns.
        rr_rand  = 1'b0;
        rr_force = 1'b0;
        issue(1'b1, 6'd7, 8'hAF, 1'b0);
        issue(1'b0, 6'd7, 8'h00, 1'b0);
        req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_req_ready", 32'(req_ready), 32'd0);
        chk("midreset_init_done", 32'(init_done), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_hold_valid", 32'(rsp_valid), 32'd0);
        rr_force = 1'b1;
        sweep_check(6'd7);
        read_lat(6'd7);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
